// File: rtl/rng_pkg.sv
// Shared definitions for the rng generator and its scheduler.
//   RNG_BITS       : width of one generator sample
//   sched_state_t  : scheduler state encoding
//   RNG_SEED/TAPS  : generator seed and feedback taps (also used by reference models)
//   rng_step       : one generator advance (16-bit Galois LFSR)
package rng_pkg;

  localparam int unsigned RNG_BITS = 3;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_FLUSH = 2'd2
  } sched_state_t;

  localparam logic [15:0] RNG_SEED = 16'hACE1;
  localparam logic [15:0] RNG_TAPS = 16'hB400;

  function automatic logic [15:0] rng_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? RNG_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/rng_scheduler_if.sv
// Bundle between the randomness consumers/generator and rng_scheduler.
//   rnd_in  : generator sample, one per clk
//   req     : level request per requester
//   reseed  : single-cycle reseed request
//   gnt     : one-hot single-cycle grant
//   rnd_out : delivered word, valid with gnt
//   rng_rst : reset line for the generator
interface rng_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WORD_W  = 12
);
  import rng_pkg::*;

  logic [RNG_BITS-1:0] rnd_in;
  logic [NUM_REQ-1:0]  req;
  logic                reseed;
  logic [NUM_REQ-1:0]  gnt;
  logic [WORD_W-1:0]   rnd_out;
  logic                rng_rst;

  modport master (output rnd_in, req, reseed, input gnt, rnd_out, rng_rst);
  modport slave  (input rnd_in, req, reseed, output gnt, rnd_out, rng_rst);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the previous winner; search starts at ptr+1 and wraps
//   grant : one-hot winner (all zero when req is zero)
//   idx   : winner index (zero when req is zero)
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((ptr + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/rng_scheduler.sv
// Collects consecutive rng samples into WORD_W-bit words and hands each
// word to exactly one requester (round-robin). Owns the generator reset so
// a reseed restarts the generator without a global reset.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of rng_scheduler_if (rnd_in, req, reseed in;
//              gnt, rnd_out, rng_rst out)
module rng_scheduler
  import rng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WORD_W  = 12
) (
  input  logic            clk,
  input  logic            rst,
  rng_scheduler_if.slave  bus
);

  localparam int unsigned SAMPLES = WORD_W / RNG_BITS;
  localparam int unsigned CNT_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  shreg;
  logic [WORD_W-1:0]  rnd_out_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               rng_rst_q;
  logic [PTR_W-1:0]   ptr;

  logic [NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]   win_idx;

  rr_arbiter #(
    .N    (NUM_REQ),
    .IDX_W(PTR_W)
  ) u_arb (
    .req  (bus.req),
    .ptr  (ptr),
    .grant(win_onehot),
    .idx  (win_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FILL;
      cnt       <= '0;
      shreg     <= '0;
      rnd_out_q <= '0;
      gnt_q     <= '0;
      rng_rst_q <= 1'b0;
      ptr       <= PTR_W'(NUM_REQ - 1);
    end else begin
      gnt_q     <= '0;
      rng_rst_q <= 1'b0;
      // Reseed overrides everything, including a grant due this edge:
      // the completed or partial word is dropped and requests stay pending.
      if (bus.reseed) begin
        state     <= ST_FLUSH;
        shreg     <= '0;
        cnt       <= '0;
        rng_rst_q <= 1'b1;
      end else begin
        case (state)
          ST_FILL: begin
            shreg <= {shreg[WORD_W-RNG_BITS-1:0], bus.rnd_in};
            if (cnt == CNT_W'(SAMPLES - 1)) begin
              cnt   <= '0;
              state <= ST_READY;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          ST_READY: begin
            if (|bus.req) begin
              gnt_q     <= win_onehot;
              rnd_out_q <= shreg;
              ptr       <= win_idx;
              cnt       <= '0;
              state     <= ST_FILL;
            end
          end
          // The generator is held in reset this cycle, so its sample is skipped.
          ST_FLUSH: state <= ST_FILL;
          default:  state <= ST_FILL;
        endcase
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.rnd_out = rnd_out_q;
  assign bus.rng_rst = rst | rng_rst_q;

endmodule
